// File: rtl/sum_accumulator.sv
// ---------------------------------------------------------------------------
// sum_accumulator
//
// Collects BATCH results from an upstream 4-bit adder ({c_out,sum}, 0..31)
// into a saturating ACC_W-bit total, then holds the completed total until a
// downstream consumer takes it.
//
// State machine:
//   IDLE  : no results in the current batch (count == 0)
//   ACCUM : 0 < count < BATCH
//   HOLD  : batch complete, acc_valid = 1, no further results accepted
//
// Ports:
//   clk       in   single clock, all state changes on the rising edge
//   rst       in   synchronous active-high reset (highest priority)
//   clear     in   synchronous batch abort (beats accept and out_ready)
//   in_valid  in   upstream adder result present
//   sum       in   adder sum bits [3:0]
//   c_out     in   adder carry-out
//   in_ready  out  block accepts a result this cycle (IDLE or ACCUM)
//   acc       out  running / final batch total, saturates at 2^ACC_W-1
//   count     out  results accepted in the current batch
//   acc_valid out  batch complete, acc holds the final total
//   ovf       out  sticky saturation flag for the current batch
//   out_ready in   downstream consumes the completed batch (HOLD only)
// ---------------------------------------------------------------------------
module sum_accumulator #(
  parameter int BATCH = 4,   // results per batch, legal 1..8
  parameter int ACC_W = 6    // accumulator width, legal 6..12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [3:0]       sum,
  input  logic             c_out,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc,
  output logic [3:0]       count,
  output logic             acc_valid,
  output logic             ovf,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX    = {ACC_W{1'b1}};
  localparam logic [3:0]       BATCH_LAST = 4'(BATCH);

  state_t           state;
  logic [ACC_W:0]   sum_ext;     // one extra bit to detect saturation
  logic [ACC_W-1:0] acc_next;
  logic             sat;
  logic [3:0]       count_next;

  // Ready depends only on the state register, never on in_valid.
  assign in_ready = (state != HOLD);

  // NOTE: every output of an always_comb block gets a default first so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sum_ext    = '0;
    acc_next   = acc;
    sat        = 1'b0;
    count_next = count + 4'd1;
    // The 5-bit operand is zero-extended before the add; since 31 < 2^ACC_W,
    // a single carry bit is enough to flag overflow.
    sum_ext    = {1'b0, acc} + (ACC_W+1)'({c_out, sum});
    sat        = sum_ext[ACC_W];
    acc_next   = sat ? ACC_MAX : sum_ext[ACC_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      acc_valid <= 1'b0;
    end else if (clear) begin
      // Abort wins over a simultaneous accept or consume.
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      acc_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (in_valid) begin
            acc   <= acc_next;
            count <= count_next;
            ovf   <= ovf | sat;
            // With BATCH == 1 the first accept completes the batch, so IDLE
            // goes straight to HOLD.
            if (count_next == BATCH_LAST) begin
              state     <= HOLD;
              acc_valid <= 1'b1;
            end else begin
              state     <= ACCUM;
            end
          end
        end
        HOLD: begin
          // Consume edge: return to an empty batch; in_ready is 0 here, so
          // nothing is accepted on this edge.
          if (out_ready) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            acc_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          acc       <= '0;
          count     <= '0;
          ovf       <= 1'b0;
          acc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_sum_accumulator
//
// Directed, table-driven bench for sum_accumulator (BATCH=4, ACC_W=6), plus a
// BATCH=1 instance sharing the same inputs for the IDLE->HOLD shortcut.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst, clear, in_valid, c_out, out_ready;
  logic [3:0] sum;

  logic       in_ready, acc_valid, ovf;
  logic [5:0] acc;
  logic [3:0] count;

  logic       b1_in_ready, b1_acc_valid, b1_ovf;
  logic [5:0] b1_acc;
  logic [3:0] b1_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sum_accumulator #(.BATCH(4), .ACC_W(6)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .sum(sum), .c_out(c_out), .in_ready(in_ready), .acc(acc),
    .count(count), .acc_valid(acc_valid), .ovf(ovf), .out_ready(out_ready)
  );

  sum_accumulator #(.BATCH(1), .ACC_W(6)) dut_b1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .sum(sum), .c_out(c_out), .in_ready(b1_in_ready), .acc(b1_acc),
    .count(b1_count), .acc_valid(b1_acc_valid), .ovf(b1_ovf),
    .out_ready(out_ready)
  );

  typedef struct {
    logic       clear;
    logic       in_valid;
    logic       c_out;
    logic [3:0] sum;
    logic       out_ready;
    int         exp_acc;
    int         exp_count;
    logic       exp_valid;
    logic       exp_ovf;
    logic       exp_ready;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_main(input string tag, input int e_acc, input int e_cnt,
                            input logic e_av, input logic e_ovf, input logic e_rdy);
    check({tag, ".acc"},       int'(acc),       e_acc);
    check({tag, ".count"},     int'(count),     e_cnt);
    check({tag, ".acc_valid"}, int'(acc_valid), int'(e_av));
    check({tag, ".ovf"},       int'(ovf),       int'(e_ovf));
    check({tag, ".in_ready"},  int'(in_ready),  int'(e_rdy));
  endtask

  // Advance one rising edge; outputs are stable when this returns.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic cl, input logic iv,
                       input logic co, input logic [3:0] s, input logic ordy);
    rst = r; clear = cl; in_valid = iv; c_out = co; sum = s; out_ready = ordy;
  endtask

  function automatic vec_t mk(input logic cl, input logic iv, input logic co,
                              input logic [3:0] s, input logic ordy,
                              input int ea, input int ec, input logic ev,
                              input logic eo, input logic er);
    vec_t v;
    v.clear = cl; v.in_valid = iv; v.c_out = co; v.sum = s; v.out_ready = ordy;
    v.exp_acc = ea; v.exp_count = ec; v.exp_valid = ev; v.exp_ovf = eo;
    v.exp_ready = er;
    return v;
  endfunction

  initial begin
    // ---- stimulus table: {clear,in_valid,c_out,sum,out_ready} -> expected
    // back-to-back 1,2,3,4
    vecs.push_back(mk(0,1,0,4'd1,0,  1,1,0,0,1));
    vecs.push_back(mk(0,1,0,4'd2,0,  3,2,0,0,1));
    vecs.push_back(mk(0,1,0,4'd3,0,  6,3,0,0,1));
    vecs.push_back(mk(0,1,0,4'd4,0, 10,4,1,0,0));
    // HOLD, out_ready=0, in_valid=1 for 5 cycles: nothing accepted
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0,1,0,4'd7,0, 10,4,1,0,0));
    // consume
    vecs.push_back(mk(0,0,0,4'd0,1,  0,0,0,0,1));
    // out_ready ignored outside HOLD: accept still happens
    vecs.push_back(mk(0,1,0,4'd2,1,  2,1,0,0,1));
    // clear with in_valid discards the result
    vecs.push_back(mk(1,1,0,4'd3,0,  0,0,0,0,1));
    // 31 four times: saturation and sticky ovf
    vecs.push_back(mk(0,1,1,4'd15,0, 31,1,0,0,1));
    vecs.push_back(mk(0,1,1,4'd15,0, 62,2,0,0,1));
    vecs.push_back(mk(0,1,1,4'd15,0, 63,3,0,1,1));
    vecs.push_back(mk(0,1,1,4'd15,0, 63,4,1,1,0));
    vecs.push_back(mk(0,0,0,4'd0,0,  63,4,1,1,0));
    vecs.push_back(mk(0,0,0,4'd0,1,   0,0,0,0,1));
    // 9, idle cycle, 9, clear+in_valid, then 5,5,5,5
    vecs.push_back(mk(0,1,0,4'd9,0,   9,1,0,0,1));
    vecs.push_back(mk(0,0,0,4'd9,0,   9,1,0,0,1));
    vecs.push_back(mk(0,1,0,4'd9,0,  18,2,0,0,1));
    vecs.push_back(mk(1,1,0,4'd9,0,   0,0,0,0,1));
    vecs.push_back(mk(0,1,0,4'd5,0,   5,1,0,0,1));
    vecs.push_back(mk(0,1,0,4'd5,0,  10,2,0,0,1));
    vecs.push_back(mk(0,1,0,4'd5,0,  15,3,0,0,1));
    vecs.push_back(mk(0,1,0,4'd5,0,  20,4,1,0,0));
    // clear beats out_ready in HOLD (same end state, clear path)
    vecs.push_back(mk(1,1,0,4'd5,1,   0,0,0,0,1));

    // ---- reset held 2 cycles with in_valid=1, operand 7
    drive(1,0,1,0,4'd7,0);
    step();
    step();
    check_main("rst_hold", 0,0,0,0,1);
    drive(0,0,0,0,4'd0,0);
    step();
    check_main("rst_release", 0,0,0,0,1);

    // ---- table
    foreach (vecs[i]) begin
      drive(0, vecs[i].clear, vecs[i].in_valid, vecs[i].c_out, vecs[i].sum,
            vecs[i].out_ready);
      step();
      check_main($sformatf("vec%0d", i), vecs[i].exp_acc, vecs[i].exp_count,
                 vecs[i].exp_valid, vecs[i].exp_ovf, vecs[i].exp_ready);
    end

    // ---- rst and clear together in HOLD
    for (int i = 0; i < 4; i++) begin
      drive(0,0,1,0,4'd1,0);
      step();
    end
    check_main("fill_hold", 4,4,1,0,0);
    drive(1,1,1,0,4'd1,1);
    step();
    check_main("rst_clear_hold", 0,0,0,0,1);

    // ---- rst mid-batch at count=2
    drive(0,0,1,0,4'd3,0);
    step();
    step();
    check_main("mid_batch", 6,2,0,0,1);
    drive(1,0,1,0,4'd3,0);
    step();
    check_main("rst_mid", 0,0,0,0,1);

    // ---- BATCH=1 instance: single accept goes straight to HOLD
    drive(0,0,1,0,4'd7,0);
    step();
    check_main("b4_one", 7,1,0,0,1);
    check("b1.acc",       int'(b1_acc),       7);
    check("b1.count",     int'(b1_count),     1);
    check("b1.acc_valid", int'(b1_acc_valid), 1);
    check("b1.in_ready",  int'(b1_in_ready),  0);
    drive(0,0,1,0,4'd7,0);
    step();
    check("b1.hold_acc",  int'(b1_acc),       7);
    check_main("b4_two", 14,2,0,0,1);
    drive(0,0,0,0,4'd0,1);
    step();
    check("b1.consume_valid", int'(b1_acc_valid), 0);
    check("b1.consume_ready", int'(b1_in_ready),  1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 SHALL have parameter BATCH, default 4, number of adder results summed per batch (legal 1..8).
REQ-002 SHALL have parameter ACC_W, default 6, accumulator width in bits (legal 6..12).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port clear  input  1  synchronous batch abort.
REQ-006 SHALL have port in_valid  input  1  upstream adder result present.
REQ-007 SHALL have port sum  input  4  adder sum bits.
REQ-008 SHALL have port c_out  input  1  adder carry-out.
REQ-009 SHALL have port in_ready  output  1  block can accept a result this cycle.
REQ-010 SHALL have port acc  output  ACC_W  running or final batch total.
REQ-011 SHALL have port count  output  4  results accepted in the current batch.
REQ-012 SHALL have port acc_valid  output  1  batch complete, acc holds the final total.
REQ-013 SHALL have port ovf  output  1  sticky saturation flag for the current batch.
REQ-014 SHALL have port out_ready  input  1  downstream consumes the completed batch.

Function
REQ-015 SHALL form the 5-bit operand {c_out,sum}, range 0..31, zero-extended to ACC_W+1 bits before the add.
REQ-016 SHALL implement exactly three states: IDLE (count=0), ACCUM (0<count<BATCH), HOLD (batch complete).
REQ-017 SHALL drive in_ready=1 in IDLE and ACCUM, and 0 in HOLD; in_ready SHALL be a function of state only.
REQ-018 SHALL accept a result when in_valid and in_ready are both 1 at a rising edge; in_valid without in_ready SHALL have no effect.
REQ-019 SHALL, on accept, update acc to acc+operand and increment count, both visible the cycle after the accept edge (latency 1).
REQ-020 SHALL saturate acc at 2^ACC_W-1 when the sum exceeds it, and set ovf; ovf SHALL stay 1 until the batch is consumed, cleared or reset.
REQ-021 SHALL transition IDLE->ACCUM on accept when BATCH>1, and ACCUM->HOLD on the accept that makes count=BATCH.
REQ-022 SHALL transition IDLE->HOLD directly on accept when BATCH=1.
REQ-023 SHALL assert acc_valid=1 only in HOLD, starting the cycle after the BATCH-th accept.
REQ-024 SHALL, in HOLD with out_ready=0, hold acc, count, ovf and acc_valid unchanged indefinitely.
REQ-025 SHALL, in HOLD with out_ready=1 at an edge, go to IDLE with acc=0, count=0, ovf=0, acc_valid=0 next cycle; no result is accepted on that edge.
REQ-026 SHALL ignore out_ready outside HOLD.
REQ-027 SHALL, when clear=1 at an edge in any state, go to IDLE with acc=0, count=0, ovf=0, acc_valid=0; a simultaneous in_valid SHALL be discarded.
REQ-028 SHALL give clear priority over accept and over out_ready.

Reset
REQ-029 SHALL, when rst=1 at an edge, enter IDLE with acc=0, count=0, ovf=0, acc_valid=0, in_ready=1 next cycle.
REQ-030 SHALL give rst priority over clear, in_valid and out_ready, including mid-batch and in HOLD.
REQ-031 SHALL NOT use rst asynchronously; outputs change only on clk edges.

Verification (BATCH=4, ACC_W=6)
REQ-032 SHALL cover: rst=1 for 2 cycles with in_valid=1 and operand 7 -> acc=0, count=0, acc_valid=0, ovf=0, in_ready=1 after release.
REQ-033 SHALL cover: back-to-back operands 1,2,3,4 -> acc=1,3,6,10 cycle by cycle; count=4, acc_valid=1, in_ready=0 the cycle after the 4th.
REQ-034 SHALL cover: HOLD with acc=10 and out_ready=0 for 5 cycles, in_valid=1 -> acc stays 10, nothing accepted; out_ready=1 -> next cycle acc=0, acc_valid=0, in_ready=1.
REQ-035 SHALL cover: operands {c_out=1,sum=15}=31 four times -> acc=31, 62, 63 (ovf=1), 63; acc_valid=1 with ovf=1.
REQ-036 SHALL cover: operands 9,9 then clear=1 with in_valid=1 -> acc=0, count=0; then 5,5,5,5 -> acc=20, ovf=0.
REQ-037 SHALL cover: rst=1 and clear=1 together in HOLD, and rst at count=2 -> IDLE with all outputs at reset values next cycle.
